// File: rtl/axis_pkt_arbiter_pkg.sv
// Shared types for the packet arbiter: FSM state encoding and ownership helpers.
package axis_pkt_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam int NUM_SRC = 2;

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry registered output stage: an output register plus one skid entry,
// with a registered ready so no combinational path runs from sink to source.
module axis_skid_reg #(
  parameter int W = 513
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] wr_data,
  input  logic         wr_valid,
  output logic         wr_ready,
  output logic [W-1:0] rd_data,
  output logic         rd_valid,
  input  logic         rd_ready
);

  logic [W-1:0] out_data_reg, out_data_next;
  logic         out_valid_reg, out_valid_next;
  logic [W-1:0] skid_data_reg, skid_data_next;
  logic         skid_valid_reg, skid_valid_next;
  logic         ready_reg;
  logic         push, pop;

  always_comb begin
    push            = wr_valid & ready_reg;
    pop             = out_valid_reg & rd_ready;
    out_data_next   = out_data_reg;
    out_valid_next  = out_valid_reg;
    skid_data_next  = skid_data_reg;
    skid_valid_next = skid_valid_reg;
    // push only happens with the skid entry empty, since ready mirrors it
    if (push) begin
      if (!out_valid_reg || pop) begin
        out_data_next  = wr_data;
        out_valid_next = 1'b1;
      end else begin
        skid_data_next  = wr_data;
        skid_valid_next = 1'b1;
      end
    end else if (pop) begin
      if (skid_valid_reg) begin
        out_data_next   = skid_data_reg;
        skid_valid_next = 1'b0;
      end else begin
        out_valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_data_reg   <= '0;
      out_valid_reg  <= 1'b0;
      skid_data_reg  <= '0;
      skid_valid_reg <= 1'b0;
      ready_reg      <= 1'b0;
    end else begin
      out_data_reg   <= out_data_next;
      out_valid_reg  <= out_valid_next;
      skid_data_reg  <= skid_data_next;
      skid_valid_reg <= skid_valid_next;
      ready_reg      <= ~skid_valid_next;
    end
  end

  assign wr_ready = ready_reg;
  assign rd_data  = out_data_reg;
  assign rd_valid = out_valid_reg;

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin arbiter merging two AXI-stream sources into one
// registered output; ownership is held from first beat through tlast.
module axis_pkt_arbiter
  import axis_pkt_arbiter_pkg::*;
#(
  parameter int DW = 512,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [DW-1:0] axis0_tdata,
  input  logic          axis0_tlast,
  input  logic          axis0_tvalid,
  output logic          axis0_tready,
  input  logic [DW-1:0] axis1_tdata,
  input  logic          axis1_tlast,
  input  logic          axis1_tvalid,
  output logic          axis1_tready,
  output logic [DW-1:0] axis_out_tdata,
  output logic          axis_out_tlast,
  output logic          axis_out_tvalid,
  input  logic          axis_out_tready,
  output logic [1:0]    grant,
  output logic [CW-1:0] pkt_count0,
  output logic [CW-1:0] pkt_count1
);

  arb_state_t    state_reg;
  logic          last_reg;
  logic [1:0]    grant_reg;
  logic [CW-1:0] count0_reg, count1_reg;

  logic          skid_ready;
  logic          wr_valid;
  logic [DW:0]   wr_data;
  logic [DW:0]   rd_data;
  logic          fire0, fire1;

  always_comb begin
    axis0_tready = (state_reg == OWN0) & skid_ready;
    axis1_tready = (state_reg == OWN1) & skid_ready;
    fire0        = axis0_tvalid & axis0_tready;
    fire1        = axis1_tvalid & axis1_tready;
    wr_valid     = 1'b0;
    wr_data      = {axis0_tlast, axis0_tdata};
    case (state_reg)
      OWN0: wr_valid = axis0_tvalid;
      OWN1: begin
        wr_valid = axis1_tvalid;
        wr_data  = {axis1_tlast, axis1_tdata};
      end
      default: wr_valid = 1'b0;
    endcase
  end

  // last_reg names the input that finished most recently; the other one wins a tie
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      last_reg   <= 1'b1;
      grant_reg  <= 2'b00;
      count0_reg <= '0;
      count1_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (axis0_tvalid && (!axis1_tvalid || last_reg)) begin
            state_reg <= OWN0;
            grant_reg <= 2'b01;
          end else if (axis1_tvalid) begin
            state_reg <= OWN1;
            grant_reg <= 2'b10;
          end
        end
        OWN0: begin
          if (fire0 && axis0_tlast) begin
            state_reg  <= IDLE;
            grant_reg  <= 2'b00;
            last_reg   <= 1'b0;
            count0_reg <= count0_reg + 1'b1;
          end
        end
        OWN1: begin
          if (fire1 && axis1_tlast) begin
            state_reg  <= IDLE;
            grant_reg  <= 2'b00;
            last_reg   <= 1'b1;
            count1_reg <= count1_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          grant_reg <= 2'b00;
        end
      endcase
    end
  end

  axis_skid_reg #(.W(DW + 1)) u_skid (
    .clk      (clk),
    .resetn   (resetn),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (skid_ready),
    .rd_data  (rd_data),
    .rd_valid (axis_out_tvalid),
    .rd_ready (axis_out_tready)
  );

  assign axis_out_tlast = rd_data[DW];
  assign axis_out_tdata = rd_data[DW-1:0];
  assign grant          = grant_reg;
  assign pkt_count0     = count0_reg;
  assign pkt_count1     = count1_reg;

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Directed bench for axis_pkt_arbiter: a cycle table for the basic grant/latency
// behaviour, then hand-written sequences for ties, backpressure, gaps, reset and wrap.
`timescale 1ns/1ps
module tb_axis_pkt_arbiter;

  localparam int DW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] d0, d1, od;
  logic          l0, v0, r0, l1, v1, r1, ol, ov, ordy;
  logic [1:0]    grant;
  logic [CW-1:0] c0, c1;

  int tests = 0;
  int fails = 0;

  axis_pkt_arbiter #(.DW(DW), .CW(CW)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .axis0_tdata     (d0),
    .axis0_tlast     (l0),
    .axis0_tvalid    (v0),
    .axis0_tready    (r0),
    .axis1_tdata     (d1),
    .axis1_tlast     (l1),
    .axis1_tvalid    (v1),
    .axis1_tready    (r1),
    .axis_out_tdata  (od),
    .axis_out_tlast  (ol),
    .axis_out_tvalid (ov),
    .axis_out_tready (ordy),
    .grant           (grant),
    .pkt_count0      (c0),
    .pkt_count1      (c1)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // output beats captured as {tlast, tdata}
  logic [DW:0] mon_q[$];
  always @(posedge clk) begin
    if (resetn && ov && ordy) mon_q.push_back({ol, od});
  end

  // stall checks, only armed during the backpressure test
  bit          chk_en = 0;
  logic        stall_prev = 1'b0;
  logic [DW:0] held = '0;
  int          in_cnt = 0, out_cnt = 0;
  always @(posedge clk) begin
    if (chk_en) begin
      if (stall_prev && ov) check("stable_while_stalled", {15'd0, ol, od}, {15'd0, held});
      check("inflight_le_2", 32'(((in_cnt - out_cnt) <= 2) ? 1 : 0), 32'd1);
    end
    stall_prev <= ov && !ordy;
    held       <= {ol, od};
    in_cnt     <= in_cnt + ((v0 && r0) ? 1 : 0);
    out_cnt    <= out_cnt + ((ov && ordy) ? 1 : 0);
  end

  // gap test: while in1 owns, nothing else may be granted
  bit gap_en = 0, s1_done = 0;
  always @(negedge clk) begin
    if (gap_en && !s1_done && grant != 2'b00) begin
      check("gap_grant", {30'd0, grant}, 32'd2);
      check("gap_in0_tready", {31'd0, r0}, 32'd0);
    end
  end

  task automatic do_reset();
    resetn = 1'b0;
    v0 = 0; v1 = 0; l0 = 0; l1 = 0; d0 = '0; d1 = '0; ordy = 1'b1;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    mon_q.delete();
  endtask

  // drives one packet; leaves tvalid high after the last accepted beat
  task automatic send_pkt(input int src, input int n, input logic [DW-1:0] base,
                          input int gap_at, input int gap_len, output bit ok);
    int beat = 0, gap = 0, guard = 0;
    logic rdy;
    ok = 1;
    while (beat < n) begin
      @(negedge clk);
      guard++;
      if (guard > 2000) begin ok = 0; break; end
      if (beat == gap_at && gap < gap_len) begin
        if (src == 0) v0 = 0; else v1 = 0;
        gap++;
        continue;
      end
      if (src == 0) begin
        v0 = 1; d0 = base + DW'(beat); l0 = (beat == n - 1); rdy = r0;
      end else begin
        v1 = 1; d1 = base + DW'(beat); l1 = (beat == n - 1); rdy = r1;
      end
      if (rdy) beat++;
    end
  endtask

  typedef struct {
    logic v0, l0; logic [DW-1:0] d0;
    logic v1, l1; logic [DW-1:0] d1;
    logic [1:0] g; logic r0, r1, ov, ol; logic [DW-1:0] od; logic [CW-1:0] c0, c1;
  } vec_t;

  function automatic vec_t mk(logic a_v0, logic a_l0, logic [DW-1:0] a_d0,
                              logic a_v1, logic a_l1, logic [DW-1:0] a_d1,
                              logic [1:0] e_g, logic e_r0, logic e_r1, logic e_ov,
                              logic e_ol, logic [DW-1:0] e_od, logic [CW-1:0] e_c0,
                              logic [CW-1:0] e_c1);
    vec_t v;
    v.v0 = a_v0; v.l0 = a_l0; v.d0 = a_d0; v.v1 = a_v1; v.l1 = a_l1; v.d1 = a_d1;
    v.g = e_g; v.r0 = e_r0; v.r1 = e_r1; v.ov = e_ov; v.ol = e_ol; v.od = e_od;
    v.c0 = e_c0; v.c1 = e_c1;
    return v;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[13];
    bit ok, ok1;
    logic [DW:0] exp_beat;
    logic pat[4];

    // single source 4-beat packet, then a tie after in0 finished last
    tbl[0]  = mk(1,0,16'h1000, 0,0,16'h0000, 2'b00,0,0, 0,0,16'h0000, 0,0);
    tbl[1]  = mk(1,0,16'h1000, 0,0,16'h0000, 2'b01,1,0, 0,0,16'h0000, 0,0);
    tbl[2]  = mk(1,0,16'h1001, 0,0,16'h0000, 2'b01,1,0, 1,0,16'h1000, 0,0);
    tbl[3]  = mk(1,0,16'h1002, 0,0,16'h0000, 2'b01,1,0, 1,0,16'h1001, 0,0);
    tbl[4]  = mk(1,1,16'h1003, 0,0,16'h0000, 2'b01,1,0, 1,0,16'h1002, 0,0);
    tbl[5]  = mk(0,0,16'h0000, 0,0,16'h0000, 2'b00,0,0, 1,1,16'h1003, 1,0);
    tbl[6]  = mk(0,0,16'h0000, 0,0,16'h0000, 2'b00,0,0, 0,0,16'h0000, 1,0);
    tbl[7]  = mk(1,1,16'h2000, 1,1,16'h3000, 2'b00,0,0, 0,0,16'h0000, 1,0);
    tbl[8]  = mk(1,1,16'h2000, 1,1,16'h3000, 2'b10,0,1, 0,0,16'h0000, 1,0);
    tbl[9]  = mk(1,1,16'h2000, 0,0,16'h0000, 2'b00,0,0, 1,1,16'h3000, 1,1);
    tbl[10] = mk(1,1,16'h2000, 0,0,16'h0000, 2'b01,1,0, 0,0,16'h0000, 1,1);
    tbl[11] = mk(0,0,16'h0000, 0,0,16'h0000, 2'b00,0,0, 1,1,16'h2000, 2,1);
    tbl[12] = mk(0,0,16'h0000, 0,0,16'h0000, 2'b00,0,0, 0,0,16'h0000, 2,1);

    // reset with both sources requesting
    resetn = 1'b0; ordy = 1'b1;
    v0 = 1; v1 = 1; l0 = 1; l1 = 1; d0 = 16'hAAAA; d1 = 16'h5555;
    repeat (3) @(negedge clk);
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_tready0", {31'd0, r0}, 32'd0);
    check("rst_tready1", {31'd0, r1}, 32'd0);
    check("rst_out_valid", {31'd0, ov}, 32'd0);
    check("rst_out_data", {15'd0, ol, od}, 32'd0);
    check("rst_counts", {24'd0, c1, c0}, 32'd0);

    do_reset();
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      v0 = tbl[i].v0; l0 = tbl[i].l0; d0 = tbl[i].d0;
      v1 = tbl[i].v1; l1 = tbl[i].l1; d1 = tbl[i].d1;
      check($sformatf("tbl%0d_grant", i), {30'd0, grant}, {30'd0, tbl[i].g});
      check($sformatf("tbl%0d_tready", i), {30'd0, r1, r0}, {30'd0, tbl[i].r1, tbl[i].r0});
      check($sformatf("tbl%0d_out_valid", i), {31'd0, ov}, {31'd0, tbl[i].ov});
      if (tbl[i].ov)
        check($sformatf("tbl%0d_out_beat", i), {15'd0, ol, od}, {15'd0, tbl[i].ol, tbl[i].od});
      check($sformatf("tbl%0d_counts", i), {24'd0, c1, c0}, {24'd0, tbl[i].c1, tbl[i].c0});
    end

    // round-robin on continuous ties: 4 x 2-beat packets per input
    do_reset();
    fork
      begin
        for (int p = 0; p < 4; p++) begin
          send_pkt(0, 2, DW'(16'h0000 + p * 16), -1, 0, ok);
          check("rr_src0_done", {31'd0, ok}, 32'd1);
        end
        @(negedge clk) v0 = 0;
      end
      begin
        for (int p = 0; p < 4; p++) begin
          send_pkt(1, 2, DW'(16'h8000 + p * 16), -1, 0, ok1);
          check("rr_src1_done", {31'd0, ok1}, 32'd1);
        end
        @(negedge clk) v1 = 0;
      end
    join
    repeat (6) @(negedge clk);
    check("rr_beats", mon_q.size(), 32'd16);
    for (int k = 0; k < 16 && k < mon_q.size(); k++) begin
      exp_beat = {(k % 2) == 1, DW'(((k / 2) % 2) * 16'h8000 + (k / 4) * 16 + (k % 2))};
      check($sformatf("rr_beat%0d", k), {15'd0, mon_q[k]}, {15'd0, exp_beat});
    end
    check("rr_count0", {28'd0, c0}, 32'd4);
    check("rr_count1", {28'd0, c1}, 32'd4);

    // backpressure: out_tready pattern 1,0,0,1 during an 8-beat packet
    do_reset();
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    chk_en = 1;
    fork
      begin
        send_pkt(0, 8, 16'h4000, -1, 0, ok);
        check("bp_src_done", {31'd0, ok}, 32'd1);
        @(negedge clk) v0 = 0;
      end
      begin
        for (int i = 0; i < 40; i++) begin
          @(negedge clk) ordy = pat[i % 4];
        end
      end
    join
    ordy = 1'b1;
    repeat (4) @(negedge clk);
    chk_en = 0;
    check("bp_beats", mon_q.size(), 32'd8);
    for (int k = 0; k < 8 && k < mon_q.size(); k++)
      check($sformatf("bp_beat%0d", k), {15'd0, mon_q[k]}, {15'd0, k == 7, DW'(16'h4000 + k)});
    check("bp_count0", {28'd0, c0}, 32'd1);

    // owner gap: in1 owns and idles 5 cycles mid-packet while in0 waits
    do_reset();
    gap_en = 1; s1_done = 0;
    fork
      begin
        send_pkt(1, 6, 16'h5000, 2, 5, ok1);
        s1_done = 1;
        check("gap_src1_done", {31'd0, ok1}, 32'd1);
        @(negedge clk) v1 = 0;
      end
      begin
        repeat (3) @(negedge clk);
        send_pkt(0, 2, 16'h5100, -1, 0, ok);
        check("gap_src0_done", {31'd0, ok}, 32'd1);
        @(negedge clk) v0 = 0;
      end
    join
    gap_en = 0;
    repeat (4) @(negedge clk);
    check("gap_beats", mon_q.size(), 32'd8);
    for (int k = 0; k < 8 && k < mon_q.size(); k++) begin
      if (k < 6) exp_beat = {k == 5, DW'(16'h5000 + k)};
      else       exp_beat = {k == 7, DW'(16'h5100 + k - 6)};
      check($sformatf("gap_beat%0d", k), {15'd0, mon_q[k]}, {15'd0, exp_beat});
    end
    check("gap_counts", {24'd0, c1, c0}, 32'h11);

    // mid-packet reset after in0 completed a packet (in1 would otherwise win the tie)
    do_reset();
    send_pkt(0, 1, 16'h6000, -1, 0, ok);
    check("mr_first_done", {31'd0, ok}, 32'd1);
    @(negedge clk) v0 = 0;
    @(negedge clk) begin v0 = 1; d0 = 16'h6100; l0 = 0; end
    @(negedge clk);
    @(negedge clk) d0 = 16'h6101;
    @(negedge clk) begin d0 = 16'h6102; resetn = 1'b0; end
    #1;
    check("mr_out_valid", {31'd0, ov}, 32'd0);
    check("mr_out_data", {15'd0, ol, od}, 32'd0);
    check("mr_grant", {30'd0, grant}, 32'd0);
    check("mr_tready", {30'd0, r1, r0}, 32'd0);
    check("mr_count0", {28'd0, c0}, 32'd0);
    v0 = 1; d0 = 16'h6200; l0 = 1;
    v1 = 1; d1 = 16'h7200; l1 = 1;
    @(negedge clk) begin resetn = 1'b1; mon_q.delete(); end
    @(negedge clk);
    check("mr_tie_grant", {30'd0, grant}, 32'd1);
    @(negedge clk) v0 = 0;
    @(negedge clk) check("mr_in1_tready", {31'd0, r1}, 32'd1);
    @(negedge clk) v1 = 0;
    repeat (3) @(negedge clk);
    check("mr_beats", mon_q.size(), 32'd2);
    if (mon_q.size() >= 2) begin
      check("mr_beat0", {15'd0, mon_q[0]}, {15'd0, 1'b1, 16'h6200});
      check("mr_beat1", {15'd0, mon_q[1]}, {15'd0, 1'b1, 16'h7200});
    end

    // counter wrap with CW=4: 16 single-beat packets on in0
    do_reset();
    for (int p = 0; p < 16; p++) begin
      send_pkt(0, 1, DW'(16'h9000 + p), -1, 0, ok);
      @(negedge clk) v0 = 0;
      check($sformatf("wrap_count_%0d", p), {28'd0, c0}, 32'((p + 1) % 16));
    end
    check("wrap_count1", {28'd0, c1}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
